// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM encoding and default limits for clock frequency monitors
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        COMPARE = 2'd2
    } state_t;

    // 1 ms gate at the nominal 9.85 MHz debug oscillator
    localparam int GATE_CYCLES_DEF = 9850;
    localparam int CNT_W_DEF       = 16;
    // clk_2M5 edges per window for a nominal 2.46 MHz system clock, +/- ~2.5 %
    localparam int EXP_MIN_DEF     = 2400;
    localparam int EXP_MAX_DEF     = 2520;
    localparam int FAIL_LIMIT_DEF  = 3;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus toggle edge detect for an asynchronous square wave
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tgl,
    output logic o_edge
);

    logic [2:0] r_sync;

    // r_sync[1:0] resolve metastability, r_sync[2] holds the previous settled level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[1:0], i_tgl};
    end

    // every level change of the toggle is one source-clock edge
    assign o_edge = r_sync[1] ^ r_sync[2];

endmodule

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: gated edge counter on clk_debug checking the system clock rate; CLK_FREQ_MON_MINMAX_EN adds min/max tracking
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int FAIL_LIMIT  = FAIL_LIMIT_DEF
) (
    input  logic             clk_debug,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             meas_tgl,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] count,
    output logic             count_vld,
    output logic             freq_ok,
    output logic             fault,
    output logic             sticky_fault
`ifdef CLK_FREQ_MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_seen,
    output logic [CNT_W-1:0] max_seen
`endif
);

    localparam int TW = $clog2(GATE_CYCLES + 1);
    localparam int FW = $clog2(FAIL_LIMIT + 1);

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_count_vld;
    logic             r_freq_ok;
    logic [FW-1:0]    r_fail_cnt;
    logic             r_fault;
    logic             r_sticky;

    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_in_rng;
    logic [FW-1:0]    w_fail_nxt;
    logic             w_fault_nxt;

    sync_edge_det u_sync (
        .i_clk   (clk_debug),
        .i_rst_n (rst_n),
        .i_tgl   (meas_tgl),
        .o_edge  (w_edge)
    );

    assign w_cnt_inc   = (w_edge && r_edge_cnt != '1) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_in_rng    = (r_edge_cnt >= CNT_W'(EXP_MIN)) && (r_edge_cnt <= CNT_W'(EXP_MAX));
    assign w_fail_nxt  = w_in_rng ? '0 :
                         (r_fail_cnt == FW'(FAIL_LIMIT)) ? r_fail_cnt : r_fail_cnt + 1'b1;
    // fault only changes at the end of a window; elsewhere it holds
    assign w_fault_nxt = (r_state == COMPARE) ? (w_fail_nxt == FW'(FAIL_LIMIT)) : r_fault;

    // measurement FSM: gate timing, edge counting, window evaluation and fault flags
    always_ff @(posedge clk_debug) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_edge_cnt  <= '0;
            r_count     <= '0;
            r_count_vld <= 1'b0;
            r_freq_ok   <= 1'b0;
            r_fail_cnt  <= '0;
            r_fault     <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_count_vld <= 1'b0;
            r_sticky    <= w_fault_nxt | (r_sticky & ~fault_clr);
            case (r_state)
                IDLE: begin
                    r_edge_cnt <= '0;
                    r_timer    <= '0;
                    if (enable) begin
                        r_timer <= TW'(GATE_CYCLES - 1);
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        r_edge_cnt <= '0;
                        r_timer    <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_edge_cnt <= w_cnt_inc;
                        r_timer    <= r_timer - 1'b1;
                        if (r_timer == '0) r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_count     <= r_edge_cnt;
                    r_count_vld <= 1'b1;
                    r_freq_ok   <= w_in_rng;
                    r_fail_cnt  <= w_fail_nxt;
                    r_fault     <= w_fault_nxt;
                    r_timer     <= TW'(GATE_CYCLES - 1);
                    // an edge seen during this cycle belongs to the next window
                    r_edge_cnt  <= {{(CNT_W-1){1'b0}}, w_edge};
                    r_state     <= MEASURE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign count        = r_count;
    assign count_vld    = r_count_vld;
    assign freq_ok      = r_freq_ok;
    assign fault        = r_fault;
    assign sticky_fault = r_sticky;

`ifdef CLK_FREQ_MON_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    // extreme window counts seen since reset or the last fault_clr
    always_ff @(posedge clk_debug) begin
        if (!rst_n || fault_clr) begin
            r_min <= '1;
            r_max <= '0;
        end else if (r_state == COMPARE) begin
            if (r_edge_cnt < r_min) r_min <= r_edge_cnt;
            if (r_edge_cnt > r_max) r_max <= r_edge_cnt;
        end
    end

    assign min_seen = r_min;
    assign max_seen = r_max;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor: scoreboard bench for clk_freq_monitor with a scaled-down gate window
module tb_clk_freq_monitor;

    localparam int GATE = 1000;
    localparam int CW   = 8;
    localparam int WIN  = GATE + 1;

    typedef struct {
        int cnt;
        int ok;
        int f;
        int s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          meas_tgl = 1'b0;
    logic          fault_clr = 1'b0;
    logic [CW-1:0] count;
    logic          count_vld;
    logic          freq_ok;
    logic          fault;
    logic          sticky_fault;
`ifdef CLK_FREQ_MON_MINMAX_EN
    logic [CW-1:0] min_seen;
    logic [CW-1:0] max_seen;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    // 14 directed windows: edges driven, expected count, freq_ok, fault, sticky, fault_clr mid-window
    int vn[14]   = '{246, 0, 0, 0, 0, 246, 246, 240, 252, 239, 253, 260, 240, 252};
    int vc[14]   = '{246, 0, 0, 0, 0, 246, 246, 240, 252, 239, 253, 255, 240, 252};
    int vok[14]  = '{  1, 0, 0, 0, 0,   1,   1,   1,   1,   0,   0,   0,   1,   1};
    int vf[14]   = '{  0, 0, 0, 1, 1,   0,   0,   0,   0,   0,   0,   1,   0,   0};
    int vs[14]   = '{  0, 0, 0, 1, 1,   1,   0,   0,   0,   0,   0,   1,   1,   0};
    int vclr[14] = '{  0, 0, 0, 0, 1,   0,   1,   0,   0,   0,   0,   0,   0,   1};

    clk_freq_monitor #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CW),
        .EXP_MIN     (240),
        .EXP_MAX     (252),
        .FAIL_LIMIT  (3)
    ) dut (
        .clk_debug    (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .meas_tgl     (meas_tgl),
        .fault_clr    (fault_clr),
        .count        (count),
        .count_vld    (count_vld),
        .freq_ok      (freq_ok),
        .fault        (fault),
        .sticky_fault (sticky_fault)
`ifdef CLK_FREQ_MON_MINMAX_EN
        ,
        .min_seen     (min_seen),
        .max_seen     (max_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int ok, input int f, input int s);
        exp_t e;
        e.cnt = c;
        e.ok  = ok;
        e.f   = f;
        e.s   = s;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_vld"}, int'(count_vld), 0);
        chk({tag, "_freq_ok"}, int'(freq_ok), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_sticky"}, int'(sticky_fault), 0);
    endtask

    // one window-aligned stretch of WIN cycles: n toggles from cycle 20, optional clear/drop/reset at cycle 500
    task automatic run_window(input int n, input bit clr, input int sexp, input bit drop, input bit rst);
        for (int c = 0; c < WIN; c++) begin
            @(posedge clk);
            #1;
            if (c >= 20 && c < 20 + 3 * n && (c - 20) % 3 == 0) meas_tgl = ~meas_tgl;
            if (clr && c == 500) fault_clr = 1'b1;
            if (clr && c == 501) fault_clr = 1'b0;
            if (clr && c == 502) chk("sticky_after_clr", int'(sticky_fault), sexp);
            if (drop && c == 500) enable = 1'b0;
            if (rst && c == 500) begin
                enable   = 1'b0;
                meas_tgl = 1'b0;
                rst_n    = 1'b0;
            end
            if (rst && c == 503) rst_n = 1'b1;
            if (rst && c == 504) chk_zero("midreset");
        end
    endtask

    // monitor: every count_vld pulse is matched against the oldest expected window
    always @(negedge clk) begin
        if (rst_n && count_vld) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_count_vld actual=count %0d expected=no pulse", count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("freq_ok", int'(freq_ok), e.ok);
                chk("fault", int'(fault), e.f);
                chk("sticky_fault", int'(sticky_fault), e.s);
            end
        end
    end

    initial begin
        int k;
        repeat (5) @(posedge clk);
        #1;
        chk_zero("reset");
`ifdef CLK_FREQ_MON_MINMAX_EN
        chk("reset_min_seen", int'(min_seen), 255);
        chk("reset_max_seen", int'(max_seen), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            push(vc[i], vok[i], vf[i], vs[i]);
            run_window(vn[i], vclr[i] != 0, vs[i], 1'b0, 1'b0);
        end
        run_window(100, 1'b0, 0, 1'b1, 1'b0);
        repeat (700) @(posedge clk);
        #1;
        chk("drop_count_kept", int'(count), 252);
        chk("drop_freq_ok_kept", int'(freq_ok), 1);
        chk("drop_fault_kept", int'(fault), 0);
        chk("drop_sticky_kept", int'(sticky_fault), 0);
`ifdef CLK_FREQ_MON_MINMAX_EN
        chk("min_seen_after_clr", int'(min_seen), 252);
        chk("max_seen_after_clr", int'(max_seen), 252);
`endif
        enable = 1'b1;
        push(246, 1, 0, 0);
        run_window(246, 1'b0, 0, 1'b0, 1'b0);
        run_window(100, 1'b0, 0, 1'b0, 1'b1);
        push(0, 0, 0, 0);
        enable = 1'b1;
        k = 0;
        while (k < 3 * WIN) begin
            @(posedge clk);
            #1;
            k++;
            if (count_vld) break;
        end
        chk("restart_latency", k - 1, GATE + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
